// File: rtl/line_memory_if.sv
// rtl/line_memory_if.sv - request/status signals between a cache and line_memory
interface line_memory_if;
    logic        readM;
    logic        writeM;
    logic [15:0] address_to_memory;
    logic        mem_ready;
    logic        mem_busy;
    logic [15:0] read_count;
    logic [15:0] write_count;

    modport master (
        output readM, writeM, address_to_memory,
        input  mem_ready, mem_busy, read_count, write_count
    );

    modport slave (
        input  readM, writeM, address_to_memory,
        output mem_ready, mem_busy, read_count, write_count
    );
endinterface

// File: rtl/line_memory.sv
// rtl/line_memory.sv - fixed-latency 64-bit line memory with shared tristate line bus
module line_memory #(
    parameter int LATENCY    = 4,
    parameter int ADDR_LINES = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    line_memory_if.slave bus,
    inout  wire  [63:0]  data_between_memory
);
    localparam int         DEPTH   = 1 << ADDR_LINES;
    localparam logic [3:0] CNT_LD  = 4'(LATENCY - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic                  accept;
    logic                  commit;
    logic                  op_write;
    logic [ADDR_LINES-1:0] line_idx;
    logic [63:0]           wr_hold;
    logic                  mem_ready_r;
    logic                  mem_busy_r;
    logic [15:0]           read_cnt;
    logic [15:0]           write_cnt;
    logic [63:0]           mem [DEPTH];

    // Address bits outside the line index are deliberately dropped (wrap-around).
    logic unused_addr;
    assign unused_addr = ^{bus.address_to_memory[15:ADDR_LINES+2], bus.address_to_memory[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.readM || bus.writeM) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_LD;
                    accept    = 1'b1;
                end
            end
            WAIT: begin
                // Counter runs LATENCY-1 .. 0; DONE is entered LATENCY edges after accept.
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    commit    = op_write;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            op_write    <= 1'b0;
            line_idx    <= '0;
            wr_hold     <= 64'd0;
            mem_ready_r <= 1'b0;
            mem_busy_r  <= 1'b0;
            read_cnt    <= 16'd0;
            write_cnt   <= 16'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mem_ready_r <= (state_nxt == DONE);
            mem_busy_r  <= (state_nxt != IDLE);
            if (accept) begin
                op_write <= bus.writeM;
                line_idx <= bus.address_to_memory[ADDR_LINES+1:2];
                // A simultaneous read+write request is taken as a write only.
                if (bus.writeM) begin
                    wr_hold <= data_between_memory;
                    if (write_cnt != CNT_MAX) write_cnt <= write_cnt + 16'd1;
                end else if (read_cnt != CNT_MAX) begin
                    read_cnt <= read_cnt + 16'd1;
                end
            end
        end
    end

    // Array is not reset; commit is only raised in WAIT, which reset forces away.
    always_ff @(posedge clk) begin
        if (commit) mem[line_idx] <= wr_hold;
    end

    assign data_between_memory = (state == DONE && !op_write) ? mem[line_idx] : {64{1'bz}};

    assign bus.mem_ready   = mem_ready_r;
    assign bus.mem_busy    = mem_busy_r;
    assign bus.read_count  = read_cnt;
    assign bus.write_count = write_cnt;
endmodule
